// File: rtl/uart_baud_ctrl.sv
// Divisor owner for baud_gen: validated divisor writes, TX/RX drain and one-cycle counter restart.
// Optional auto-baud start-bit measurement is built when UART_AUTOBAUD_EN is defined.
module uart_baud_ctrl #(
    parameter int DVSR_W    = 11,
    parameter int DVSR_RST  = 326,
    parameter int ABD_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DVSR_W-1:0] cfg_dvsr,
    input  logic              tx_busy,
    input  logic              rx_busy,
    input  logic              rxd_sync,
    input  logic              abd_start,
    output logic [DVSR_W-1:0] dvsr,
    output logic              baud_clr,
    output logic              hold,
    output logic              cfg_err,
    output logic              abd_done,
    output logic              abd_fail
);

`ifdef UART_AUTOBAUD_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        APPLY    = 3'd2,
        ABD_FALL = 3'd3,
        ABD_LOW  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        APPLY = 3'd2
    } state_t;
`endif

    state_t            stateQ, stateD;
    logic [DVSR_W-1:0] dvsrQ, dvsrD;
    logic [DVSR_W-1:0] pendQ, pendD;
    logic              cfgReadyQ, cfgReadyD;
    logic              holdQ, holdD;
    logic              baudClrQ, baudClrD;
    logic              cfgErrQ, cfgErrD;

    logic handshake;
    logic cfgBad;
    logic drained;

    assign handshake = cfg_valid & cfgReadyQ;
    assign cfgBad    = (cfg_dvsr < DVSR_W'(2));
    assign drained   = ~tx_busy & ~rx_busy;

`ifdef UART_AUTOBAUD_EN
    logic                 abdFlagQ, abdFlagD;
    logic                 abdDoneQ, abdDoneD;
    logic                 abdFailQ, abdFailD;
    logic [ABD_CNT_W-1:0] cntQ, cntD;
    logic                 rxdPrevQ;

    logic                 abdReq;
    logic                 fallEdge;
    logic                 cntSat;
    logic [ABD_CNT_W:0]   abdSum;
    logic [ABD_CNT_W:0]   abdCand;
    logic                 candOk;

    assign abdReq   = abd_start & ~cfg_valid;
    assign fallEdge = rxdPrevQ & ~rxd_sync;
    assign cntSat   = (cntQ == {ABD_CNT_W{1'b1}});
    // Low time spans 16 baud ticks; add half a tick before dividing to round to nearest.
    assign abdSum   = {1'b0, cntQ} + (ABD_CNT_W + 1)'(8);
    assign abdCand  = abdSum >> 4;
    assign candOk   = (abdCand >= (ABD_CNT_W + 1)'(2)) && ((abdCand >> DVSR_W) == '0);
`else
    logic unusedAbdInputs;
    assign unusedAbdInputs = ^{abd_start, rxd_sync, (ABD_CNT_W > 0)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            dvsrQ     <= DVSR_W'(DVSR_RST);
            pendQ     <= '0;
            cfgReadyQ <= 1'b1;
            holdQ     <= 1'b0;
            baudClrQ  <= 1'b0;
            cfgErrQ   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            dvsrQ     <= dvsrD;
            pendQ     <= pendD;
            cfgReadyQ <= cfgReadyD;
            holdQ     <= holdD;
            baudClrQ  <= baudClrD;
            cfgErrQ   <= cfgErrD;
        end
    end

`ifdef UART_AUTOBAUD_EN
    // Line idles high, so the edge detector starts from 1 to avoid a false fall after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abdFlagQ <= 1'b0;
            abdDoneQ <= 1'b0;
            abdFailQ <= 1'b0;
            cntQ     <= '0;
            rxdPrevQ <= 1'b1;
        end else begin
            abdFlagQ <= abdFlagD;
            abdDoneQ <= abdDoneD;
            abdFailQ <= abdFailD;
            cntQ     <= cntD;
            rxdPrevQ <= rxd_sync;
        end
    end
`endif

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            IDLE: begin
                if (handshake && !cfgBad) begin
                    stateD = DRAIN;
                end
`ifdef UART_AUTOBAUD_EN
                else if (abdReq) begin
                    stateD = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (drained) begin
`ifdef UART_AUTOBAUD_EN
                    stateD = abdFlagQ ? ABD_FALL : APPLY;
`else
                    stateD = APPLY;
`endif
                end
            end
            APPLY: begin
                stateD = IDLE;
            end
`ifdef UART_AUTOBAUD_EN
            ABD_FALL: begin
                if (fallEdge) begin
                    stateD = ABD_LOW;
                end else if (cntSat) begin
                    stateD = IDLE;
                end
            end
            ABD_LOW: begin
                if (rxd_sync) begin
                    stateD = candOk ? APPLY : IDLE;
                end else if (cntSat) begin
                    stateD = IDLE;
                end
            end
`endif
            default: stateD = IDLE;
        endcase
    end

    // Handshake/hold/clear outputs follow the next state so every output leaves a flop.
    always_comb begin
        dvsrD     = dvsrQ;
        pendD     = pendQ;
        cfgReadyD = (stateD == IDLE);
        holdD     = (stateD != IDLE);
        baudClrD  = (stateD == APPLY);
        cfgErrD   = 1'b0;
`ifdef UART_AUTOBAUD_EN
        abdFlagD  = abdFlagQ;
        abdDoneD  = 1'b0;
        abdFailD  = 1'b0;
        cntD      = cntQ;
`endif
        unique case (stateQ)
            IDLE: begin
                if (handshake) begin
                    if (cfgBad) begin
                        cfgErrD = 1'b1;
                    end else begin
                        pendD = cfg_dvsr;
                    end
                end
`ifdef UART_AUTOBAUD_EN
                else if (abdReq) begin
                    abdFlagD = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (stateD == APPLY) begin
                    dvsrD = pendQ;
                end
`ifdef UART_AUTOBAUD_EN
                cntD = '0;
`endif
            end
            APPLY: begin
`ifdef UART_AUTOBAUD_EN
                abdDoneD = abdFlagQ;
                abdFlagD = 1'b0;
`endif
            end
`ifdef UART_AUTOBAUD_EN
            ABD_FALL: begin
                if (fallEdge) begin
                    cntD = ABD_CNT_W'(1);
                end else if (cntSat) begin
                    abdFailD = 1'b1;
                    abdFlagD = 1'b0;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            ABD_LOW: begin
                if (rxd_sync) begin
                    if (candOk) begin
                        dvsrD = abdCand[DVSR_W-1:0];
                    end else begin
                        abdFailD = 1'b1;
                        abdFlagD = 1'b0;
                    end
                end else if (cntSat) begin
                    abdFailD = 1'b1;
                    abdFlagD = 1'b0;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign dvsr      = dvsrQ;
    assign cfg_ready = cfgReadyQ;
    assign hold      = holdQ;
    assign baud_clr  = baudClrQ;
    assign cfg_err   = cfgErrQ;
`ifdef UART_AUTOBAUD_EN
    assign abd_done  = abdDoneQ;
    assign abd_fail  = abdFailQ;
`else
    assign abd_done  = 1'b0;
    assign abd_fail  = 1'b0;
`endif

endmodule
